// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, instruction codes, IR capture pattern.
// The optional IDCODE register is enabled by defining TAP_IDCODE_EN.
package tap_pkg;

  localparam int IR_WIDTH = 4;

  // Standard 1149.1 state encoding, 4 bits per state
  typedef enum logic [3:0] {
    ST_EX2_DR  = 4'h0,
    ST_EX1_DR  = 4'h1,
    ST_SH_DR   = 4'h2,
    ST_PAU_DR  = 4'h3,
    ST_SEL_IR  = 4'h4,
    ST_UPD_DR  = 4'h5,
    ST_CAP_DR  = 4'h6,
    ST_SEL_DR  = 4'h7,
    ST_EX2_IR  = 4'h8,
    ST_EX1_IR  = 4'h9,
    ST_SH_IR   = 4'hA,
    ST_PAU_IR  = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPD_IR  = 4'hD,
    ST_CAP_IR  = 4'hE,
    ST_TLR     = 4'hF
  } tap_state_t;

  localparam logic [3:0] INSTR_IDCODE   = 4'h1;
  localparam logic [3:0] INSTR_GETTEST  = 4'h2;
  localparam logic [3:0] INSTR_RUNBIST  = 4'h3;
  localparam logic [3:0] INSTR_SETSTATE = 4'h4;
  localparam logic [3:0] INSTR_BYPASS   = 4'hF;

  // Loaded into the IR shift register in Capture-IR; LSB-first reads 1,0,1,0
  localparam logic [3:0] IR_CAPTURE     = 4'b0101;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP controller FSM with one-hot decodes of the states the
// data path acts on.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       tlr,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir
);

  // State register: standard 1149.1 transitions sampled on TMS
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state <= ST_TLR;
    end else begin
      case (state)
        ST_TLR:    state <= tms ? ST_TLR    : ST_RTI;
        ST_RTI:    state <= tms ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR: state <= tms ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR: state <= tms ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:  state <= tms ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR: state <= tms ? ST_UPD_DR : ST_PAU_DR;
        ST_PAU_DR: state <= tms ? ST_EX2_DR : ST_PAU_DR;
        ST_EX2_DR: state <= tms ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR: state <= tms ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR: state <= tms ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR: state <= tms ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:  state <= tms ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR: state <= tms ? ST_UPD_IR : ST_PAU_IR;
        ST_PAU_IR: state <= tms ? ST_EX2_IR : ST_PAU_IR;
        ST_EX2_IR: state <= tms ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR: state <= tms ? ST_SEL_DR : ST_RTI;
      endcase
    end
  end

  // State decodes are purely combinational so they follow TRST immediately
  assign tlr    = (state == ST_TLR);
  assign cap_dr = (state == ST_CAP_DR);
  assign sh_dr  = (state == ST_SH_DR);
  assign upd_dr = (state == ST_UPD_DR);
  assign cap_ir = (state == ST_CAP_IR);
  assign sh_ir  = (state == ST_SH_IR);
  assign upd_ir = (state == ST_UPD_IR);

endmodule

// File: rtl/tap_bist_ctrl.sv
// TAP controller for the JTAG BIST block: instruction register, BIST data
// shift register, bypass bit and TDO mux. Define TAP_IDCODE_EN to add the
// 32-bit IDCODE register and make IDCODE the reset instruction.
module tap_bist_ctrl
  import tap_pkg::*;
#(
  parameter int IR_WIDTH  = 4,
  parameter int BSR_WIDTH = 10
`ifdef TAP_IDCODE_EN
  , parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
`endif
) (
  input  logic                 TCK,
  input  logic                 TRST,
  input  logic                 TMS,
  input  logic                 TDI,
  output logic                 TDO,
  input  logic [7:0]           BIST_DATA,
  output logic                 TLR,
  output logic                 UPDATEDR,
  output logic                 RUNBIST_SELECT,
  output logic                 GETTEST_SELECT,
  output logic                 SETSTATE_SELECT,
  output logic [BSR_WIDTH-1:0] BSR,
  output logic [IR_WIDTH-1:0]  IR
);

`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_IR = IR_WIDTH'(INSTR_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR = IR_WIDTH'(INSTR_BYPASS);
`endif

  tap_state_t          fsm_state;
  logic                tlr, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir;
  logic [IR_WIDTH-1:0] ir_shift_reg;
  logic [IR_WIDTH-1:0] ir_reg;
  logic [BSR_WIDTH-1:0] bsr_reg;
  logic                bypass_reg;
  logic                bsr_sel;
  logic                idcode_sel;
  logic                tdo_bit;

  tap_fsm u_fsm (
    .tck    (TCK),
    .trst   (TRST),
    .tms    (TMS),
    .state  (fsm_state),
    .tlr    (tlr),
    .cap_dr (cap_dr),
    .sh_dr  (sh_dr),
    .upd_dr (upd_dr),
    .cap_ir (cap_ir),
    .sh_ir  (sh_ir),
    .upd_ir (upd_ir)
  );

  // Instruction decodes; IR only moves in Update-IR/TLR so these are stable during DR scans
  assign GETTEST_SELECT  = (ir_reg == IR_WIDTH'(INSTR_GETTEST));
  assign RUNBIST_SELECT  = (ir_reg == IR_WIDTH'(INSTR_RUNBIST));
  assign SETSTATE_SELECT = (ir_reg == IR_WIDTH'(INSTR_SETSTATE));
  assign bsr_sel         = GETTEST_SELECT | RUNBIST_SELECT | SETSTATE_SELECT;
`ifdef TAP_IDCODE_EN
  assign idcode_sel      = (ir_reg == IR_WIDTH'(INSTR_IDCODE));
`else
  assign idcode_sel      = 1'b0;
`endif

  // IR shift register captures 0101, shifts right; IR takes it in Update-IR, reset value in TLR
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_reg <= '0;
      ir_reg       <= RESET_IR;
    end else begin
      if (cap_ir)
        ir_shift_reg <= IR_WIDTH'(IR_CAPTURE);
      else if (sh_ir)
        ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
      if (tlr)
        ir_reg <= RESET_IR;
      else if (upd_ir)
        ir_reg <= ir_shift_reg;
    end
  end

  // BIST data register: RUNBIST captures results, GETTEST/SETSTATE keep the last word for rescans
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bsr_reg <= '0;
    end else if (bsr_sel) begin
      if (cap_dr && RUNBIST_SELECT)
        bsr_reg <= BSR_WIDTH'(BIST_DATA);
      else if (sh_dr)
        bsr_reg <= {TDI, bsr_reg[BSR_WIDTH-1:1]};
    end
  end

  // Bypass bit serves every instruction that has no dedicated data register
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_reg <= 1'b0;
    end else if (!bsr_sel && !idcode_sel) begin
      if (cap_dr)
        bypass_reg <= 1'b0;
      else if (sh_dr)
        bypass_reg <= TDI;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_reg;

  // Device ID register, reloaded on every Capture-DR under IDCODE
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_reg <= '0;
    end else if (idcode_sel) begin
      if (cap_dr)
        idcode_reg <= IDCODE_VAL;
      else if (sh_dr)
        idcode_reg <= {TDI, idcode_reg[31:1]};
    end
  end
`endif

  // TDO presents the selected shift-register LSB only while shifting
  always_comb begin
    tdo_bit = 1'b0;
    case (fsm_state)
      ST_SH_IR: tdo_bit = ir_shift_reg[0];
      ST_SH_DR: begin
        if (bsr_sel)
          tdo_bit = bsr_reg[0];
`ifdef TAP_IDCODE_EN
        else if (idcode_sel)
          tdo_bit = idcode_reg[0];
`endif
        else
          tdo_bit = bypass_reg;
      end
      default: tdo_bit = 1'b0;
    endcase
  end

  assign TDO      = tdo_bit;
  assign TLR      = tlr;
  assign UPDATEDR = upd_dr;
  assign BSR      = bsr_reg;
  assign IR       = ir_reg;

endmodule

// File: tb/tb_tap_bist_ctrl.sv
// Self-checking bench for tap_bist_ctrl. Works with or without TAP_IDCODE_EN.
module tb_tap_bist_ctrl;

  localparam logic [31:0] IDV = 32'h1000_0001;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic [7:0] BIST_DATA = 8'h00;
  logic       TDO, TLR, UPDATEDR, RUNBIST_SELECT, GETTEST_SELECT, SETSTATE_SELECT;
  logic [9:0] BSR;
  logic [3:0] IR;

  int checks = 0;
  int failures = 0;

  // Transaction-level model: current instruction and BIST register contents
  logic [3:0] m_ir;
  logic [9:0] m_bsr;

  tap_bist_ctrl dut (
    .TCK             (TCK),
    .TRST            (TRST),
    .TMS             (TMS),
    .TDI             (TDI),
    .TDO             (TDO),
    .BIST_DATA       (BIST_DATA),
    .TLR             (TLR),
    .UPDATEDR        (UPDATEDR),
    .RUNBIST_SELECT  (RUNBIST_SELECT),
    .GETTEST_SELECT  (GETTEST_SELECT),
    .SETSTATE_SELECT (SETSTATE_SELECT),
    .BSR             (BSR),
    .IR              (IR)
  );

  always #5 TCK = ~TCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive inputs away from the edge, sample 1 time unit after it
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  // 0 = bypass bit, 1 = BIST register, 2 = IDCODE register
  function automatic int kind_of(input logic [3:0] ir);
    if (ir == 4'h2 || ir == 4'h3 || ir == 4'h4) return 1;
`ifdef TAP_IDCODE_EN
    if (ir == 4'h1) return 2;
`endif
    return 0;
  endfunction

  task automatic chk_selects(input string tag);
    chk(tag, {29'd0, GETTEST_SELECT, RUNBIST_SELECT, SETSTATE_SELECT},
        {29'd0, m_ir == 4'h2, m_ir == 4'h3, m_ir == 4'h4});
  endtask

  // IR scan from RTI back to RTI, checking captured bits on TDO
  task automatic scan_ir(input logic [3:0] code);
    bit q[$];
    logic [3:0] cap;
    cap = 4'b0101;
    for (int i = 0; i < 4; i++) q.push_back(cap[i]);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ir_tdo[%0d]", i), {31'd0, TDO}, {31'd0, q.pop_front()});
      step(i == 3, code[i]);
    end
    chk("ir_exit_tdo", {31'd0, TDO}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    m_ir = code;
    chk("ir_value", {28'd0, IR}, {28'd0, m_ir});
    chk_selects("ir_selects");
    $display("IR scan code=%h ir=%h", code, IR);
  endtask

  // DR scan of n bits from RTI back to RTI, optional pause after pause_at bits
  task automatic scan_dr(input int n, input logic [31:0] data, input int pause_at);
    bit q[$];
    int k;
    logic [9:0] cap;
    k = kind_of(m_ir);
    if (k == 1) begin
      cap = (m_ir == 4'h3) ? {2'b00, BIST_DATA} : m_bsr;
      for (int i = 0; i < 10; i++) q.push_back(cap[i]);
    end else if (k == 2) begin
      for (int i = 0; i < 32; i++) q.push_back(IDV[i]);
    end else begin
      q.push_back(1'b0);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("dr_tdo[%0d]", i), {31'd0, TDO}, {31'd0, q.pop_front()});
      q.push_back(data[i]);
      step((i == n - 1) || (i == pause_at - 1), data[i]);
      if (i == pause_at - 1 && i != n - 1) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("pause_tdo", {31'd0, TDO}, 32'd0);
        chk("pause_upd", {31'd0, UPDATEDR}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    chk("ex1_upd", {31'd0, UPDATEDR}, 32'd0);
    step(1'b1, 1'b0);
    if (k == 1)
      for (int i = 0; i < 10; i++) m_bsr[i] = q[i];
    chk("upd_upd", {31'd0, UPDATEDR}, 32'd1);
    chk("upd_bsr", {22'd0, BSR}, {22'd0, m_bsr});
    step(1'b0, 1'b0);
    chk("rti_upd", {31'd0, UPDATEDR}, 32'd0);
    chk("rti_bsr", {22'd0, BSR}, {22'd0, m_bsr});
    $display("DR scan ir=%h n=%0d data=%h bsr=%h", m_ir, n, data, BSR);
  endtask

  initial begin
    logic [3:0] code;
    int n;
    int pz;

    // Asynchronous reset before any clock edge
    #1 TRST = 1'b1;
    #2;
    chk("rst_tlr", {31'd0, TLR}, 32'd1);
    chk("rst_upd", {31'd0, UPDATEDR}, 32'd0);
    chk("rst_sel", {29'd0, GETTEST_SELECT, RUNBIST_SELECT, SETSTATE_SELECT}, 32'd0);
    chk("rst_tdo", {31'd0, TDO}, 32'd0);
    chk("rst_ir", {28'd0, IR}, {28'd0, RST_IR});
    chk("rst_bsr", {22'd0, BSR}, 32'd0);
    @(posedge TCK);
    #1 TRST = 1'b0;
    m_ir = RST_IR;
    m_bsr = '0;
    step(1'b0, 1'b0);
    chk("rti_tlr", {31'd0, TLR}, 32'd0);
    $display("reset done tlr=%b ir=%h", TLR, IR);

`ifdef TAP_IDCODE_EN
    // First DR scan after reset returns the device ID
    scan_dr(32, $urandom, 0);
`endif

    // GETTEST load of a known word, then rescan to read it back
    scan_ir(4'h2);
    scan_dr(10, 32'(10'b1010_0110_00), 0);
    chk("gettest_bsr", {22'd0, BSR}, 32'h298);
    scan_dr(10, $urandom, 0);

    // RUNBIST capture of all-ones result
    BIST_DATA = 8'hFF;
    scan_ir(4'h3);
    scan_dr(10, $urandom, 0);

    // Illegal code behaves as a one-bit bypass
    scan_ir(4'h9);
    scan_dr(12, $urandom, 0);

    // Five TMS=1 clocks from RTI reach TLR on the third and restore IR
    scan_ir(4'h3);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0);
      chk($sformatf("tlr_walk[%0d]", i), {31'd0, TLR}, {31'd0, i >= 3});
    end
    chk("tlr_ir", {28'd0, IR}, {28'd0, RST_IR});
    m_ir = RST_IR;
    step(1'b0, 1'b0);
    $display("TLR walk done ir=%h", IR);

    // Randomized instruction / data scans
    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 5))
        0: code = 4'h2;
        1: code = 4'h3;
        2: code = 4'h4;
        3: code = 4'h1;
        4: code = 4'hF;
        default: code = 4'($urandom);
      endcase
      BIST_DATA = 8'($urandom);
      scan_ir(code);
      n = $urandom_range(1, 24);
      pz = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
      scan_dr(n, $urandom, pz);
    end

    // TRST in the middle of a GETTEST shift aborts the scan immediately
    scan_ir(4'h2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    #2 TRST = 1'b1;
    #1;
    chk("trst_tlr", {31'd0, TLR}, 32'd1);
    chk("trst_ir", {28'd0, IR}, {28'd0, RST_IR});
    chk("trst_bsr", {22'd0, BSR}, 32'd0);
    chk("trst_tdo", {31'd0, TDO}, 32'd0);
    chk("trst_sel", {29'd0, GETTEST_SELECT, RUNBIST_SELECT, SETSTATE_SELECT}, 32'd0);
    @(posedge TCK);
    #1 TRST = 1'b0;
    m_ir = RST_IR;
    m_bsr = '0;
    step(1'b0, 1'b0);
    $display("TRST abort done ir=%h bsr=%h", IR, BSR);
    scan_dr(10, $urandom, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
